// File: rtl/seg_pkg.sv
// seg_pkg: constants shared by the seven-segment scan driver and the
// downstream decoder.
//   SEG_BLANK_CODE         - nibble the decoder renders as an unlit digit
//   SEG_NUM_DIGITS_DEFAULT - default number of display positions
//   seg_idx_width()        - width of a position index (at least 1 bit)
package seg_pkg;

  localparam logic [3:0] SEG_BLANK_CODE         = 4'hF;
  localparam int         SEG_NUM_DIGITS_DEFAULT = 8;

  // Width of a counter that addresses n positions; never below one bit.
  function automatic int seg_idx_width(input int n);
    if (n > 2) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// seg_lzb_mask: leading-zero blanking mask.
// Ports:
//   digits     in  4*NUM_DIGITS  packed BCD digits, nibble 0 least significant
//   blank_en   in  1             enable for leading-zero blanking
//   blank_mask out NUM_DIGITS    bit k set when position k must show blank
// A position is blanked when it and every more-significant nibble are zero.
// Position 0 is never blanked, so a zero value still shows a single "0".
module seg_lzb_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS_DEFAULT
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    blank_en,
  output logic [NUM_DIGITS-1:0]   blank_mask
);

  logic [NUM_DIGITS-1:0] mask_s;
  logic                  zero_run_s;

  // Walk from the most significant nibble down, tracking the run of zeros.
  always_comb begin
    mask_s     = '0;
    zero_run_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run_s = zero_run_s & (digits[4*k +: 4] == 4'h0);
      mask_s[k]  = blank_en & zero_run_s;
    end
  end

  assign blank_mask = mask_s;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan driver for a common-cathode
// seven-segment display.
// Ports:
//   clk        in  1             system clock
//   rst_n      in  1             synchronous active-low reset
//   digits_in  in  4*NUM_DIGITS  packed BCD digits, nibble 0 least significant
//   digit_en   in  NUM_DIGITS    per-position enable (0 keeps position dark)
//   blank_en   in  1             leading-zero blanking enable
//   bcd_out    out 4             code to the decoder, 4'hF = blank
//   sel_n      out NUM_DIGITS    one-cold active-low digit select
//   scan_tick  out 1             last cycle of every slot
//   frame_tick out 1             last cycle of the last slot of a frame
// Inputs are captured into shadow registers only at frame boundaries (and
// on the first edge after reset), so a frame is always drawn from one
// consistent snapshot. Outputs decode registered state only.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS_DEFAULT,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   sel_n,
  output logic                    scan_tick,
  output logic                    frame_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = seg_idx_width(NUM_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM = DIV_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    load_pend_r;
  logic [4*NUM_DIGITS-1:0] digits_sh_r;
  logic [NUM_DIGITS-1:0]   digit_en_sh_r;
  logic                    blank_en_sh_r;

  logic                    slot_end_s;
  logic                    frame_end_s;
  logic                    live_s;
  logic [NUM_DIGITS-1:0]   blank_mask_s;
  logic [NUM_DIGITS-1:0]   sel_n_s;
  logic [3:0]              bcd_s;

  assign slot_end_s  = (div_cnt_r == DIV_LAST);
  assign frame_end_s = slot_end_s & (idx_r == IDX_LAST);
  // Dead time at the start of each slot keeps all cathodes off while the
  // segment lines settle to the new digit.
  assign live_s      = (div_cnt_r >= DEAD_LIM);

  // Dwell counter and position index, both with explicit wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      idx_r     <= '0;
    end else if (slot_end_s) begin
      div_cnt_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Shadow capture: pending load after reset, otherwise once per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_pend_r   <= 1'b1;
      digits_sh_r   <= '0;
      digit_en_sh_r <= '0;
      blank_en_sh_r <= 1'b0;
    end else if (load_pend_r || frame_end_s) begin
      load_pend_r   <= 1'b0;
      digits_sh_r   <= digits_in;
      digit_en_sh_r <= digit_en;
      blank_en_sh_r <= blank_en;
    end else begin
      load_pend_r   <= load_pend_r;
    end
  end

  seg_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb (
    .digits     (digits_sh_r),
    .blank_en   (blank_en_sh_r),
    .blank_mask (blank_mask_s)
  );

  // Select and code for the active position; a blanked position keeps its
  // select but is fed the blank code.
  always_comb begin
    sel_n_s = '1;
    bcd_s   = SEG_BLANK_CODE;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (live_s && (idx_r == IDX_W'(k))) begin
        sel_n_s[k] = ~digit_en_sh_r[k];
        if (blank_mask_s[k]) begin
          bcd_s = SEG_BLANK_CODE;
        end else begin
          bcd_s = digits_sh_r[4*k +: 4];
        end
      end else begin
        sel_n_s[k] = 1'b1;
      end
    end
  end

  assign sel_n      = sel_n_s;
  assign bcd_out    = bcd_s;
  assign scan_tick  = slot_end_s;
  assign frame_tick = frame_end_s;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver (NUM_DIGITS=8, SCAN_DIV=4, DEAD_CYC=1).
// A frame-position model (one integer 0..31 plus a captured snapshot) gives
// the expected outputs every cycle; directed scenarios pin literal values.
module tb_seg_scan_driver;

  localparam int ND  = 8;
  localparam int DIV = 4;
  localparam int DC  = 1;
  localparam int FRM = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   digits_in;
  logic [7:0]    digit_en;
  logic          blank_en;
  logic [3:0]    bcd_out;
  logic [7:0]    sel_n;
  logic          scan_tick;
  logic          frame_tick;

  int tests = 0;
  int fails = 0;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (DIV),
    .DEAD_CYC   (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .digit_en   (digit_en),
    .blank_en   (blank_en),
    .bcd_out    (bcd_out),
    .sel_n      (sel_n),
    .scan_tick  (scan_tick),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame and the captured snapshot.
  int          m_cyc = 0;
  logic        m_pend = 1'b1;
  logic [31:0] m_dig = '0;
  logic [7:0]  m_en = '0;
  logic        m_blank = 1'b0;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc       <= 0;
      m_pend      <= 1'b1;
      m_dig       <= '0;
      m_en        <= '0;
      m_blank     <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      if (m_pend || m_cyc == FRM - 1) begin
        m_dig   <= digits_in;
        m_en    <= digit_en;
        m_blank <= blank_en;
      end
      m_pend <= 1'b0;
      m_cyc  <= (m_cyc + 1) % FRM;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int          slot;
    int          ph;
    logic [31:0] upper;
    logic [7:0]  es;
    logic [3:0]  eb;
    logic        blk;
    if (model_valid) begin
      slot  = m_cyc / DIV;
      ph    = m_cyc % DIV;
      upper = m_dig >> (4 * slot);
      blk   = m_blank && (slot != 0) && (upper == 32'h0);
      es    = 8'hFF;
      if (ph >= DC && m_en[slot]) es[slot] = 1'b0;
      eb    = (ph < DC || blk) ? 4'hF : upper[3:0];
      check("model_sel_n", {24'h0, sel_n}, {24'h0, es});
      check("model_bcd_out", {28'h0, bcd_out}, {28'h0, eb});
      check("model_scan_tick", {31'h0, scan_tick}, {31'h0, ph == DIV - 1});
      check("model_frame_tick", {31'h0, frame_tick}, {31'h0, m_cyc == FRM - 1});
    end
  end

  logic [3:0] fr_bcd [ND];
  logic [7:0] fr_sel [ND];

  // Pulse reset; returns at the negedge one cycle after release (slot 0, phase 1).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sample each slot at phase 1, optionally changing digits_in mid-frame.
  task automatic capture_frame(input int chg_slot, input logic [31:0] chg_val);
    for (int k = 0; k < ND; k++) begin
      if (k != 0) repeat (DIV) @(negedge clk);
      fr_bcd[k] = bcd_out;
      fr_sel[k] = sel_n;
      if (k == chg_slot) digits_in = chg_val;
    end
  endtask

  initial begin
    logic [3:0] exp_b [ND];
    int         cnt;

    rst_n     = 1'b0;
    digits_in = 32'h8765_4321;
    digit_en  = 8'hFF;
    blank_en  = 1'b0;

    // Scenario 1: reset state, then first slots after release.
    repeat (3) @(negedge clk);
    check("rst_sel_n", {24'h0, sel_n}, 32'hFF);
    check("rst_bcd", {28'h0, bcd_out}, 32'hF);
    check("rst_ticks", {30'h0, scan_tick, frame_tick}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s1_pos0_sel", {24'h0, sel_n}, 32'hFE);
      check("s1_pos0_bcd", {28'h0, bcd_out}, 32'h1);
    end
    @(negedge clk);
    check("s1_dead_sel", {24'h0, sel_n}, 32'hFF);
    check("s1_dead_bcd", {28'h0, bcd_out}, 32'hF);
    @(negedge clk);
    check("s1_pos1_sel", {24'h0, sel_n}, 32'hFD);
    check("s1_pos1_bcd", {28'h0, bcd_out}, 32'h2);

    // Scenario 2: leading zeros blanked, internal zero kept.
    digits_in = 32'h0000_1204;
    blank_en  = 1'b1;
    do_reset();
    capture_frame(-1, 32'h0);
    exp_b = '{4'h4, 4'h0, 4'h2, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF};
    for (int k = 0; k < ND; k++) begin
      check($sformatf("s2_bcd_pos%0d", k), {28'h0, fr_bcd[k]}, {28'h0, exp_b[k]});
      check($sformatf("s2_sel_pos%0d", k), {24'h0, fr_sel[k]}, {24'h0, ~(8'h01 << k)});
    end

    // Scenario 3: all zeros shows a single 0.
    digits_in = 32'h0;
    do_reset();
    capture_frame(-1, 32'h0);
    for (int k = 0; k < ND; k++)
      check($sformatf("s3_bcd_pos%0d", k), {28'h0, fr_bcd[k]}, (k == 0) ? 32'h0 : 32'hF);

    // Scenario 4: disabled positions stay dark, scan_tick keeps pulsing.
    digits_in = 32'h1234_5678;
    digit_en  = 8'h0F;
    blank_en  = 1'b0;
    do_reset();
    capture_frame(-1, 32'h0);
    for (int k = 4; k < ND; k++)
      check($sformatf("s4_sel_pos%0d", k), {24'h0, fr_sel[k]}, 32'hFF);
    cnt = 0;
    repeat (FRM) begin
      @(negedge clk);
      if (scan_tick) cnt++;
    end
    check("s4_scan_tick_count", cnt, 32'd8);

    // Scenario 5: mid-frame change takes effect only next frame.
    digits_in = 32'h1111_1111;
    digit_en  = 8'hFF;
    do_reset();
    capture_frame(3, 32'h2222_2222);
    for (int k = 3; k < ND; k++)
      check($sformatf("s5_old_pos%0d", k), {28'h0, fr_bcd[k]}, 32'h1);
    repeat (DIV) @(negedge clk);
    check("s5_new_pos0", {28'h0, bcd_out}, 32'h2);
    cnt = 0;
    repeat (2 * FRM) begin
      @(negedge clk);
      if (frame_tick) cnt++;
    end
    check("s5_frame_tick_count", cnt, 32'd2);

    // Scenario 6: reset in slot 5 at div_cnt=2, restart with fresh data.
    do_reset();
    repeat (21) @(negedge clk);
    rst_n     = 1'b0;
    digits_in = 32'h9999_9999;
    @(negedge clk);
    check("s6_rst_sel", {24'h0, sel_n}, 32'hFF);
    check("s6_rst_bcd", {28'h0, bcd_out}, 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_restart_sel", {24'h0, sel_n}, 32'hFE);
    check("s6_restart_bcd", {28'h0, bcd_out}, 32'h9);

    // Randomized run; the model compare checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        digits_in = $urandom >> (4 * $urandom_range(0, 8));
        digit_en  = 8'($urandom);
        blank_en  = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
